stage_pipe: RTL
===============

STAGE_PIPE -- requirements
Module: stage_pipe

Interface
REQ-001 Parameter STAGES, default 5, number of pipeline stages (legal range 2..16).
REQ-002 Parameter WIDTH, default 64, payload bits per stage.
REQ-003 clk  input  1  single clock, all state on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low (0 = reset asserted).
REQ-005 in_valid  input  1  upstream beat present.
REQ-006 in_data  input  WIDTH  upstream payload.
REQ-007 in_ready  output  1  stage 0 accepts this cycle.
REQ-008 out_valid  output  1  stage STAGES-1 offers a beat.
REQ-009 out_data  output  WIDTH  payload of stage STAGES-1.
REQ-010 out_ready  input  1  downstream accepts.
REQ-011 stall_req  input  STAGES  per-stage hold; bit i freezes stage i.
REQ-012 flush  input  STAGES  bit k kills stages 0..k.
REQ-013 occupancy  output  $clog2(STAGES+1)  count of valid stages.
REQ-014 retire_cnt  output  64  beats delivered downstream.
REQ-015 bubble_cnt  output  64  cycles with out_ready=1 and out_valid=0.

Function
REQ-016 Stage 0 is the youngest and stage STAGES-1 the oldest; each stage holds a valid bit and a WIDTH-bit payload register.
REQ-017 mv[STAGES-1] = v[STAGES-1] & !stall_req[STAGES-1] & out_ready; mv[i] = v[i] & !stall_req[i] & acc[i+1] for i<STAGES-1.
REQ-018 acc[i] = !stall_req[i] & (!v[i] | mv[i]); the ready chain is combinational, from out_ready to in_ready.
REQ-019 in_ready = acc[0] & (flush == 0); a transfer happens when in_valid & in_ready.
REQ-020 out_valid = v[STAGES-1] & !stall_req[STAGES-1] & !flush[STAGES-1]; out_data = payload[STAGES-1].
REQ-021 On advance, stage i+1 loads payload and valid from stage i; payload of a stage not loading holds its value.
REQ-022 A stage that releases and does not load clears its valid bit at the edge.
REQ-023 Empty-pipe latency: a beat accepted at edge N is presented on out_* after edge N+STAGES-1; throughput is 1 beat/cycle with no stalls.
REQ-024 Flush has priority over stall and advance: stages 0..k (k = highest set flush bit) are invalid after the edge; stages above k advance normally.
REQ-025 A stage with stall_req set that is empty stays empty; stall never duplicates or drops a beat.
REQ-026 occupancy reflects registered valid bits (value after the last edge).
REQ-027 retire_cnt increments on out_valid & out_ready; bubble_cnt increments on out_ready & !out_valid; both wrap modulo 2^64.

Reset
REQ-028 While reset=0 all valid bits, payloads, and counters are 0, so in_ready=1 (absent stall_req[0]/flush), out_valid=0, and occupancy=0.
REQ-029 Reset asserted mid-operation discards all in-flight beats immediately, without waiting for a clock edge.
REQ-030 Beats are accepted from the first rising edge after reset deasserts.

Configuration
REQ-031 Macro PIPE_PERF_CNT_EN: when defined, retire_cnt and bubble_cnt are implemented per REQ-027.
REQ-032 Without PIPE_PERF_CNT_EN, retire_cnt and bubble_cnt are tied to 0, no counter flops exist, and the ports remain present.

Verification (STAGES=5, WIDTH=64)
REQ-033 Reset release, in_valid=1, data 0x1..0x8 on consecutive cycles, out_ready=1 -> 0x1 appears on out_data 4 cycles after acceptance, then one beat per cycle, occupancy settles at 5.
REQ-034 Full pipe, out_ready=0 for 3 cycles -> in_ready=0, out_data held at the same value, occupancy=5, no beat lost after out_ready returns to 1.
REQ-035 stall_req[2]=1 for 2 cycles with a full pipe and out_ready=1 -> stages 3-4 drain (2 beats out), stages 0-2 hold, bubble_cnt+=1 on the 3rd cycle, order preserved.
REQ-036 flush=5'b00100 with beats 0xA..0xE in flight -> the three youngest beats are never output, in_ready=0 that cycle, the two oldest beats are delivered, occupancy=2 the next cycle.
REQ-037 flush[4]=1 together with stall_req[4]=1 and out_ready=1 -> out_valid=0, pipe empty after the edge, retire_cnt unchanged.
REQ-038 reset pulled to 0 between edges with occupancy=3 -> out_valid=0 and occupancy=0 immediately; with PIPE_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/stage_pipe.sv
// rtl/stage_pipe.sv - elastic multi-stage pipeline with per-stage stall and flush
//
// Purpose:
//   STAGES-deep pipeline. Stage 0 is the youngest and stage STAGES-1 the oldest.
//   Each stage holds one valid bit and one WIDTH-bit payload. A stage advances
//   when its successor can take the beat. The ready chain is combinational from
//   out_ready back to in_ready, so an empty slot anywhere lets the stages behind
//   it close up in the same cycle.
//
// Ports:
//   clk        in   1                  rising-edge clock
//   reset      in   1                  asynchronous reset, active low
//   in_valid   in   1                  upstream beat present
//   in_data    in   WIDTH              upstream payload
//   in_ready   out  1                  stage 0 accepts this cycle
//   out_valid  out  1                  oldest stage offers a beat
//   out_data   out  WIDTH              payload of the oldest stage
//   out_ready  in   1                  downstream accepts
//   stall_req  in   STAGES             bit i freezes stage i
//   flush      in   STAGES             bit k kills stages 0..k
//   occupancy  out  $clog2(STAGES+1)   number of valid stages
//   retire_cnt out  64                 beats delivered downstream
//   bubble_cnt out  64                 cycles with out_ready=1 and out_valid=0
//
// Configuration:
//   PIPE_PERF_CNT_EN  when defined, retire_cnt and bubble_cnt count; otherwise
//                     both ports are tied to zero and no counter flops exist.

module stage_pipe #(
  parameter int STAGES = 5,
  parameter int WIDTH  = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  input  logic                          out_ready,
  input  logic [STAGES-1:0]             stall_req,
  input  logic [STAGES-1:0]             flush,
  output logic [$clog2(STAGES+1)-1:0]   occupancy,
  output logic [63:0]                   retire_cnt,
  output logic [63:0]                   bubble_cnt
);

  localparam int OW = $clog2(STAGES+1);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];

  logic [STAGES-1:0] mv;    // stage releases its beat this cycle
  logic [STAGES-1:0] acc;   // stage can take a new beat this cycle
  logic [STAGES-1:0] kill;  // stage lies at or below the highest flush bit
  logic [STAGES-1:0] load;  // stage captures a surviving beat this cycle
  logic              in_fire;

  // Ready chain, evaluated oldest to youngest. kill[i] is the OR of flush
  // bits i and above, i.e. stage i is at or below the highest set flush bit.
  always_comb begin
    mv   = '0;
    acc  = '0;
    kill = '0;
    mv[STAGES-1]   = valid_q[STAGES-1] & ~stall_req[STAGES-1] & out_ready;
    acc[STAGES-1]  = ~stall_req[STAGES-1] & (~valid_q[STAGES-1] | mv[STAGES-1]);
    kill[STAGES-1] = flush[STAGES-1];
    for (int i = STAGES-2; i >= 0; i--) begin
      mv[i]   = valid_q[i] & ~stall_req[i] & acc[i+1];
      acc[i]  = ~stall_req[i] & (~valid_q[i] | mv[i]);
      kill[i] = flush[i] | kill[i+1];
    end
  end

  assign in_ready  = acc[0] & ~(|flush);
  assign in_fire   = in_valid & in_ready;
  assign out_valid = valid_q[STAGES-1] & ~stall_req[STAGES-1] & ~flush[STAGES-1];
  assign out_data  = data_q[STAGES-1];

  // A beat leaving a killed stage is discarded rather than handed on, so the
  // stage just above the flush point empties unless it is holding its own beat.
  always_comb begin
    load    = '0;
    valid_d = valid_q;
    load[0] = in_fire;
    for (int i = 1; i < STAGES; i++) begin
      load[i] = mv[i-1] & ~kill[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      data_d[i] = data_q[i];
      if (kill[i]) begin
        valid_d[i] = 1'b0;
      end else if (load[i]) begin
        valid_d[i] = 1'b1;
      end else if (mv[i]) begin
        valid_d[i] = 1'b0;
      end
    end
    if (load[0]) begin
      data_d[0] = in_data;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (load[i]) begin
        data_d[i] = data_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OW'(valid_q[i]);
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [63:0] retire_q, retire_d;
  logic [63:0] bubble_q, bubble_d;

  always_comb begin
    retire_d = retire_q + {63'd0, out_valid & out_ready};
    bubble_d = bubble_q + {63'd0, out_ready & ~out_valid};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_q <= '0;
      bubble_q <= '0;
    end else begin
      retire_q <= retire_d;
      bubble_q <= bubble_d;
    end
  end

  assign retire_cnt = retire_q;
  assign bubble_cnt = bubble_q;
`else
  assign retire_cnt = '0;
  assign bubble_cnt = '0;
`endif

endmodule
